sp_datapath: RTL
================

Name: sp_datapath

Overview:
- Datapath for the 8-instruction accumulator processor. It executes the control word that the control unit drives each cycle.
- Holds the registers PC, IR, memory-address register (MAR) and accumulator A, plus a 2^ADDR_W x DATA_W unified program/data RAM.
- Returns the opcode and the A status flags (aEq0, aPos) to the control unit.
- Instruction format: {opcode[OP_W-1:0], address[ADDR_W-1:0]}. Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 INPUT, 5 JZ, 6 JPOS, 7 HALT.

Parameters:
- DATA_W, 8, width of A, memory words and I/O data; must equal OP_W+ADDR_W.
- ADDR_W, 5, memory address width (32 words).
- OP_W, 3, opcode width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- irLoad  in  1  IR <= mem[MAR]
- pcLoad  in  1  PC update enable
- jmpMux  in  1  PC source: 0 = PC+1, 1 = IR address field
- memInst  in  1  MAR source: 0 = PC, 1 = IR address field
- memWr  in  1  mem[MAR] <= A
- aLoad  in  1  A load enable
- aSel  in  2  A source: 00 = ALU, 01 = dataIn, 10 = mem[MAR], 11 = zero
- sub  in  1  ALU op: 0 = A+mem[MAR], 1 = A-mem[MAR]
- dataIn  in  DATA_W  external input for INPUT
- progWe  in  1  program-load write strobe
- progAddr  in  ADDR_W  program-load address
- progData  in  DATA_W  program-load data
- irOut  out  OP_W  IR[DATA_W-1:ADDR_W], to control unit
- aEq0  out  1  A == 0
- aPos  out  1  A != 0 and A[DATA_W-1] == 0 (strictly positive)
- dataOut  out  DATA_W  current A

Behaviour:
- Reset (asynchronous, active-high): PC, IR, MAR and A clear to 0. Outputs then read irOut=0, aEq0=1, aPos=0, dataOut=0. Memory contents are retained across reset.
- MAR loads every cycle: memInst ? IR[ADDR_W-1:0] : PC.
  - The MAR value is therefore the one selected in the previous cycle.
  - Fetch: MAR=PC set in state s0; used in s1.
  - Operand: MAR=IR addr set in decode; used in execute.
- Memory read is combinational from MAR: rdata = mem[MAR].
- Memory write is synchronous.
- IR: loads rdata when irLoad=1, otherwise holds.
- PC:
  - when pcLoad=1, loads jmpMux ? IR[ADDR_W-1:0] : PC+1, otherwise holds.
  - PC+1 wraps modulo 2^ADDR_W (31 -> 0).
- A: when aLoad=1, loads the source selected by aSel, otherwise holds.
  - ALU result is (A ± rdata) modulo 2^DATA_W; no carry or overflow flag.
- aEq0, aPos and dataOut are combinational from the A register only, with no dependence on in-flight loads, so there is no combinational loop through the control unit.
- Writes:
  - memWr=1 writes A (the pre-edge value) into mem[MAR].
  - progWe=1 writes progData into mem[progAddr].
  - If progWe and memWr are both high in the same cycle, progWe wins and the memWr write is dropped, even when the addresses differ.
- Simultaneous memWr with aLoad/aSel=10 at the same address: A gets the old memory word (read-before-write).
- Simultaneous irLoad and pcLoad (fetch): IR gets mem[MAR] and PC increments, both on the same edge.
- Reset asserted mid-instruction: registers clear immediately. A write whose edge coincides with reset assertion must not occur; gate writes with ~reset.
- Program loading is only legal while the control unit sits in reset or halt. No interlock is provided beyond the priority rule above.

Decomposition:
- Package sp_pkg holds:
  - opcode constants OP_LOAD..OP_HALT;
  - aSel encodings ASEL_ALU, ASEL_IN, ASEL_MEM, ASEL_ZERO;
  - default widths.
- One natural sub-module: sp_ram, a single-port RAM with combinational read, synchronous write, and an added program-write port with the priority rule above.
- Everything else (registers, muxes, ALU) stays in sp_datapath.

Test Plan:
- Reset: preload mem[0]=8'h00, then reset, then release -> PC=0, A=0, irOut=0, aEq0=1, aPos=0.
- Fetch + LOAD:
  - Stimulus: mem[0]=8'b000_00101 (LOAD 5), mem[5]=8'h07; drive control sequence s0,s1,s2,s3.
  - Expected: irOut=0 and PC=1 after s1; A=8'h07, aPos=1 after s3.
- ADD/SUB wrap:
  - Stimulus: A=8'hFF, mem[6]=8'h02; ADD 6.
  - Expected: A=8'h01. Then SUB 6 -> A=8'hFF, aPos=0, aEq0=0.
- STORE + INPUT:
  - Stimulus: INPUT with dataIn=8'h2A (aSel=01, aLoad), then STORE 9.
  - Expected: mem[9]=8'h2A.
  - Also assert progWe (progAddr=10) in the same cycle as the STORE -> mem[9] unchanged, mem[10]=progData.
- Jumps:
  - JZ 3 with A=0 -> PC=3.
  - JZ 3 with A=1 -> PC unchanged.
  - JPOS 17 with A=8'h80 -> PC unchanged; with A=8'h01 -> PC=17.
- PC wrap: PC=31 plus a fetch -> PC=0, IR=mem[31].

Source files
------------

// File: rtl/sp_pkg.sv
// Shared widths, opcode constants and A-source encodings for the
// 8-instruction accumulator processor.
package sp_pkg;

    localparam int SP_DATA_W = 8;
    localparam int SP_ADDR_W = 5;
    localparam int SP_OP_W   = 3;

    localparam logic [SP_OP_W-1:0] OP_LOAD  = 3'd0;
    localparam logic [SP_OP_W-1:0] OP_STORE = 3'd1;
    localparam logic [SP_OP_W-1:0] OP_ADD   = 3'd2;
    localparam logic [SP_OP_W-1:0] OP_SUB   = 3'd3;
    localparam logic [SP_OP_W-1:0] OP_INPUT = 3'd4;
    localparam logic [SP_OP_W-1:0] OP_JZ    = 3'd5;
    localparam logic [SP_OP_W-1:0] OP_JPOS  = 3'd6;
    localparam logic [SP_OP_W-1:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_MEM  = 2'b10;
    localparam logic [1:0] ASEL_ZERO = 2'b11;

endpackage

// File: rtl/sp_ram.sv
// Unified program/data RAM: combinational read, synchronous write, plus a
// program-load port that takes priority over the datapath write.
module sp_ram
    import sp_pkg::*;
#(
    parameter int DATA_W = SP_DATA_W,
    parameter int ADDR_W = SP_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign rdata = mem[addr];

    // NOTE: memory has no reset term; contents must survive reset, and a
    // held-in-reset edge must not write, so reset only gates the enables.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (prog_we)
                mem[prog_addr] <= prog_data;
            else if (wr_en)
                mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sp_datapath.sv
// Datapath of the accumulator processor: PC, IR, MAR, A, ALU and the unified
// RAM, driven by a control word supplied every cycle by the control unit.
module sp_datapath
    import sp_pkg::*;
#(
    parameter int DATA_W = SP_DATA_W,
    parameter int ADDR_W = SP_ADDR_W,
    parameter int OP_W   = SP_OP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              irLoad,
    input  logic              pcLoad,
    input  logic              jmpMux,
    input  logic              memInst,
    input  logic              memWr,
    input  logic              aLoad,
    input  logic [1:0]        aSel,
    input  logic              sub,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              progWe,
    input  logic [ADDR_W-1:0] progAddr,
    input  logic [DATA_W-1:0] progData,
    output logic [OP_W-1:0]   irOut,
    output logic              aEq0,
    output logic              aPos,
    output logic [DATA_W-1:0] dataOut
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] a;

    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] a_src;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] mar_next;

    assign ir_addr  = ir[ADDR_W-1:0];
    assign pc_next  = jmpMux  ? ir_addr : pc + ADDR_W'(1);
    assign mar_next = memInst ? ir_addr : pc;
    assign alu_res  = sub ? a - rdata : a + rdata;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        a_src = '0;
        case (aSel)
            ASEL_ALU:  a_src = alu_res;
            ASEL_IN:   a_src = dataIn;
            ASEL_MEM:  a_src = rdata;
            default:   a_src = '0;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every register samples
    // pre-edge values; this is what makes STORE write the old A.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            a   <= '0;
        end else begin
            mar <= mar_next;
            if (irLoad) ir <= rdata;
            if (pcLoad) pc <= pc_next;
            if (aLoad)  a  <= a_src;
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .addr      (mar),
        .wr_en     (memWr),
        .wr_data   (a),
        .prog_we   (progWe),
        .prog_addr (progAddr),
        .prog_data (progData),
        .rdata     (rdata)
    );

    // Flags look only at the A register, never at in-flight loads.
    assign irOut   = ir[DATA_W-1:ADDR_W];
    assign aEq0    = (a == '0);
    assign aPos    = (a != '0) && !a[DATA_W-1];
    assign dataOut = a;

endmodule
